// File: rtl/interrupt_controller_pkg.sv
// Shared CPU constants and types used by the interrupt controller.
//   NBR_IRQS              : number of external IRQ lines
//   SYNC_STAGES           : flops in each IRQ input synchroniser
//   CPU_STATUS_IRQ_EN_BIT : position of the interrupt-enable bit in cpu_status
//   e_irq_state           : interrupt handshake FSM states
package interrupt_controller_pkg;

    localparam int unsigned NBR_IRQS              = 8;
    localparam int unsigned SYNC_STAGES           = 2;
    localparam int unsigned VECTOR_W              = 8;
    localparam int unsigned CPU_STATUS_IRQ_EN_BIT = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        ACKD = 2'd2
    } e_irq_state;

endpackage

// File: rtl/interrupt_controller_irq_synchronizer.sv
// One IRQ line: SYNC_STAGES-flop synchroniser followed by a rising-edge detector.
//   clk, arst  : clock, asynchronous active-high reset
//   irq_in     : asynchronous request level
//   edge_pulse : one-cycle pulse per synchronised rising edge
module irq_synchronizer #(
    parameter int unsigned SYNC_STAGES = interrupt_controller_pkg::SYNC_STAGES
) (
    input  logic clk,
    input  logic arst,
    input  logic irq_in,
    output logic edge_pulse
);
    import interrupt_controller_pkg::*;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Synchroniser chain plus one history flop for edge detection
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], irq_in};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign edge_pulse = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/interrupt_controller.sv
// Interrupt controller: synchronises IRQ lines, latches pending bits, applies the
// mask register and CPU enable, and hands the lowest-index eligible vector to the
// trap microcode through a REQ/ACK handshake.
//   clk, arst      : clock, asynchronous active-high reset
//   irq_in         : asynchronous requests (rising edge = event)
//   data_in        : z_bus, mask register source
//   irq_masks_wrt  : active-low mask load strobe
//   int_ack        : trap microcode accepts the current winner
//   clear_all_ints : flush all pending bits
//   irq_enable     : cpu_status interrupt-enable bit
//   int_pending    : request to the microcode sequencer
//   int_vector     : zero-extended winning index, updated on acceptance
//   irq_masks      : mask register (1 = enabled)
//   irq_status     : raw pending bits
module interrupt_controller #(
    parameter int unsigned NBR_IRQS    = interrupt_controller_pkg::NBR_IRQS,
    parameter int unsigned SYNC_STAGES = interrupt_controller_pkg::SYNC_STAGES
) (
    input  logic                clk,
    input  logic                arst,
    input  logic [NBR_IRQS-1:0] irq_in,
    input  logic [7:0]          data_in,
    input  logic                irq_masks_wrt,
    input  logic                int_ack,
    input  logic                clear_all_ints,
    input  logic                irq_enable,
    output logic                int_pending,
    output logic [7:0]          int_vector,
    output logic [NBR_IRQS-1:0] irq_masks,
    output logic [NBR_IRQS-1:0] irq_status
);
    import interrupt_controller_pkg::*;

    localparam int unsigned IDX_W = (NBR_IRQS > 1) ? $clog2(NBR_IRQS) : 1;

    e_irq_state          state_q, state_d;
    logic [NBR_IRQS-1:0] pending_q, pending_d;
    logic [NBR_IRQS-1:0] masks_q;
    logic [7:0]          vector_q, vector_d;
    logic                int_pending_q, int_pending_d;
    logic [NBR_IRQS-1:0] edge_pulse;
    logic [NBR_IRQS-1:0] eligible;
    logic [IDX_W-1:0]    winner;
    logic                accept;

    // One synchroniser/edge detector per line
    for (genvar g = 0; g < int'(NBR_IRQS); g++) begin : g_sync
        irq_synchronizer #(
            .SYNC_STAGES (SYNC_STAGES)
        ) u_sync (
            .clk        (clk),
            .arst       (arst),
            .irq_in     (irq_in[g]),
            .edge_pulse (edge_pulse[g])
        );
    end

    assign eligible = pending_q & masks_q & {NBR_IRQS{irq_enable}};

    // Fixed priority: lowest index wins (scan downward so the last hit is the lowest)
    always_comb begin
        winner = '0;
        for (int i = int'(NBR_IRQS) - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                winner = IDX_W'(i);
            end
        end
    end

    // Next-state, pending and vector logic; per-bit priority is clear > new edge > ack-clear
    always_comb begin
        state_d       = state_q;
        pending_d     = pending_q;
        vector_d      = vector_q;
        int_pending_d = 1'b0;
        accept        = 1'b0;

        case (state_q)
            IDLE: begin
                if (|eligible) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (int_ack && (|eligible)) begin
                    accept  = 1'b1;
                    state_d = ACKD;
                end else if (!(|eligible)) begin
                    state_d = IDLE;
                end
            end
            ACKD: begin
                // Hold here until ack drops so one ack pulse accepts at most once
                if (!int_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (accept && !clear_all_ints) begin
            vector_d          = 8'(winner);
            pending_d[winner] = 1'b0;
        end

        pending_d = pending_d | edge_pulse;

        if (clear_all_ints) begin
            state_d   = IDLE;
            pending_d = '0;
        end

        int_pending_d = (state_d == REQ);
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q       <= IDLE;
            pending_q     <= '0;
            masks_q       <= '0;
            vector_q      <= '0;
            int_pending_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pending_q     <= pending_d;
            vector_q      <= vector_d;
            int_pending_q <= int_pending_d;
            if (!irq_masks_wrt) begin
                masks_q <= data_in[NBR_IRQS-1:0];
            end
        end
    end

    assign int_pending = int_pending_q;
    assign int_vector  = vector_q;
    assign irq_masks   = masks_q;
    assign irq_status  = pending_q;

endmodule

// File: tb/tb_interrupt_controller.sv
module tb_interrupt_controller;

    localparam int unsigned N = 8;
    localparam int unsigned S = 2;

    logic         clk = 1'b0;
    logic         arst;
    logic [N-1:0] irq_in;
    logic [7:0]   data_in;
    logic         irq_masks_wrt;
    logic         int_ack;
    logic         clear_all_ints;
    logic         irq_enable;
    logic         int_pending;
    logic [7:0]   int_vector;
    logic [N-1:0] irq_masks;
    logic [N-1:0] irq_status;

    int total = 0;
    int bad   = 0;

    // Reference model: pending set, mask copy, last vector, request/ack-lock flags,
    // and the sampled irq_in history (index 0 = most recent posedge sample).
    logic [N-1:0] m_pend;
    logic [N-1:0] m_masks;
    logic [7:0]   m_vec;
    logic         m_req;
    logic         m_lock;
    logic [N-1:0] m_hist [0:S+1];

    interrupt_controller dut (
        .clk            (clk),
        .arst           (arst),
        .irq_in         (irq_in),
        .data_in        (data_in),
        .irq_masks_wrt  (irq_masks_wrt),
        .int_ack        (int_ack),
        .clear_all_ints (clear_all_ints),
        .irq_enable     (irq_enable),
        .int_pending    (int_pending),
        .int_vector     (int_vector),
        .irq_masks      (irq_masks),
        .irq_status     (irq_status)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pend  = '0;
        m_masks = '0;
        m_vec   = '0;
        m_req   = 1'b0;
        m_lock  = 1'b0;
        for (int k = 0; k <= int'(S) + 1; k++) m_hist[k] = '0;
    endtask

    // Advance the model by one posedge using the current inputs, then clock the DUT and compare.
    task automatic tick();
        logic [N-1:0] elig;
        logic [N-1:0] ev;
        int           w;
        logic         acc;
        for (int k = int'(S) + 1; k > 0; k--) m_hist[k] = m_hist[k-1];
        m_hist[0] = irq_in;
        // A line's event reaches the pending register S+1 posedges after the rise
        ev   = m_hist[S] & ~m_hist[S+1];
        elig = m_pend & m_masks & {N{irq_enable}};
        w    = 0;
        for (int i = int'(N) - 1; i >= 0; i--) if (elig[i]) w = i;
        acc  = m_req && int_ack && (elig != '0);
        if (clear_all_ints) begin
            m_pend = '0;
            m_req  = 1'b0;
            m_lock = 1'b0;
        end else begin
            if (m_lock) begin
                m_lock = int_ack;
            end else if (m_req) begin
                if (acc) begin
                    m_vec     = 8'(w);
                    m_pend[w] = 1'b0;
                    m_lock    = 1'b1;
                    m_req     = 1'b0;
                end else if (elig == '0) begin
                    m_req = 1'b0;
                end
            end else begin
                m_req = (elig != '0);
            end
            m_pend = m_pend | ev;
        end
        if (!irq_masks_wrt) m_masks = data_in[N-1:0];
        @(posedge clk);
        #1;
        check("model_status",  32'(irq_status),  32'(m_pend));
        check("model_pending", 32'(int_pending), 32'(m_req));
        check("model_vector",  32'(int_vector),  32'(m_vec));
        check("model_masks",   32'(irq_masks),   32'(m_masks));
    endtask

    task automatic write_masks(input logic [7:0] v);
        data_in       = v;
        irq_masks_wrt = 1'b0;
        tick();
        irq_masks_wrt = 1'b1;
    endtask

    initial begin
        arst           = 1'b1;
        irq_in         = '0;
        data_in        = '0;
        irq_masks_wrt  = 1'b1;
        int_ack        = 1'b0;
        clear_all_ints = 1'b0;
        irq_enable     = 1'b0;
        model_reset();

        #3;
        check("rst_pending", 32'(int_pending), 32'(0));
        check("rst_vector",  32'(int_vector),  32'(0));
        check("rst_masks",   32'(irq_masks),   32'(0));
        check("rst_status",  32'(irq_status),  32'(0));
        @(posedge clk);
        #1;
        arst = 1'b0;

        // 1: single line, full masks
        write_masks(8'hFF);
        irq_enable = 1'b1;
        irq_in[3]  = 1'b1;
        tick();
        irq_in[3]  = 1'b0;
        tick();
        tick();
        check("t1_status_after3", 32'(irq_status), 32'h08);
        tick();
        check("t1_int_pending", 32'(int_pending), 32'(1));
        int_ack = 1'b1;
        tick();
        check("t1_vector", 32'(int_vector), 32'h03);
        check("t1_status_clr", 32'(irq_status), 32'h00);
        int_ack = 1'b0;
        tick();
        tick();

        // 2: simultaneous lines 5 and 2
        irq_in = 8'h24;
        tick();
        irq_in = 8'h00;
        tick();
        tick();
        tick();
        int_ack = 1'b1;
        tick();
        check("t2_first_vector", 32'(int_vector), 32'h02);
        int_ack = 1'b0;
        tick();
        tick();
        check("t2_second_req", 32'(int_pending), 32'(1));
        int_ack = 1'b1;
        tick();
        check("t2_second_vector", 32'(int_vector), 32'h05);
        int_ack = 1'b0;
        tick();
        tick();

        // 3: pending latches while masked; unmasking raises the request
        write_masks(8'h00);
        irq_in[1] = 1'b1;
        tick();
        irq_in[1] = 1'b0;
        tick();
        tick();
        check("t3_status", 32'(irq_status), 32'h02);
        tick();
        check("t3_masked_no_req", 32'(int_pending), 32'(0));
        write_masks(8'h02);
        tick();
        check("t3_unmasked_req", 32'(int_pending), 32'(1));
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        tick();
        tick();

        // 4: clear_all_ints coinciding with a new edge on line 0
        write_masks(8'hFF);
        irq_in = 8'h11;
        tick();
        irq_in = 8'h00;
        tick();
        tick();
        tick();
        check("t4_status_pre", 32'(irq_status), 32'h11);
        check("t4_req_pre", 32'(int_pending), 32'(1));
        irq_in[0] = 1'b1;
        tick();
        tick();
        clear_all_ints = 1'b1;
        tick();
        check("t4_status_clr", 32'(irq_status), 32'h00);
        check("t4_pending_clr", 32'(int_pending), 32'(0));
        clear_all_ints = 1'b0;
        tick();
        tick();
        check("t4_level_no_rereq", 32'(irq_status), 32'h00);
        irq_in = 8'h00;
        tick();

        // 5: ack held four cycles accepts once; then async reset mid-REQ
        irq_in = 8'h06;
        tick();
        irq_in = 8'h00;
        tick();
        tick();
        tick();
        int_ack = 1'b1;
        tick();
        check("t5_vector", 32'(int_vector), 32'h01);
        tick();
        tick();
        tick();
        check("t5_one_accept", 32'(irq_status), 32'h04);
        check("t5_vector_hold", 32'(int_vector), 32'h01);
        int_ack = 1'b0;
        tick();
        tick();
        check("t5_req_again", 32'(int_pending), 32'(1));
        arst = 1'b1;
        #2;
        check("t5_arst_pending", 32'(int_pending), 32'(0));
        check("t5_arst_vector",  32'(int_vector),  32'(0));
        check("t5_arst_masks",   32'(irq_masks),   32'(0));
        check("t5_arst_status",  32'(irq_status),  32'(0));
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        arst = 1'b0;

        // Randomised traffic against the model
        write_masks(8'hFF);
        for (int c = 0; c < 400; c++) begin
            irq_in         = irq_in ^ (N'($urandom) & N'($urandom) & N'($urandom));
            irq_enable     = ($urandom_range(0, 7) != 0);
            int_ack        = ($urandom_range(0, 2) == 0);
            clear_all_ints = ($urandom_range(0, 31) == 0);
            irq_masks_wrt  = ($urandom_range(0, 15) != 0);
            data_in        = 8'($urandom);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
